// File: rtl/register_file.sv
// General-purpose CPU register file for the decode stage.
// 2**ADDR entries of BUS_W bits, two combinational read ports (rs, rt) and one
// synchronous write port (rd). Register 0 is hardwired to zero.
module register_file #(
  parameter int unsigned ADDR  = 5,
  parameter int unsigned BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_write,
  input  logic [ADDR-1:0]  rd_addr,
  input  logic [BUS_W-1:0] rd_w_data,
  input  logic [ADDR-1:0]  rs_addr,
  input  logic [ADDR-1:0]  rt_addr,
  output logic [BUS_W-1:0] rs_data,
  output logic [BUS_W-1:0] rt_data
);

  localparam int unsigned Depth = 2 ** ADDR;

  logic [BUS_W-1:0] regs_q [Depth];

  // Storage update: synchronous clear has priority; writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (r_write && (rd_addr != '0)) begin
      regs_q[rd_addr] <= rd_w_data;
    end
  end

  // Read ports: zero-latency, no write-through bypass, register 0 forced to zero.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) rs_data = regs_q[rs_addr];
    if (rt_addr != '0) rt_data = regs_q[rt_addr];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Inputs change 1ns after the rising edge; outputs are sampled after a short settle.
module tb_register_file;

  localparam int unsigned ADDR  = 5;
  localparam int unsigned BUS_W = 32;
  localparam int unsigned Depth = 2 ** ADDR;

  logic             clk;
  logic             rst;
  logic             r_write;
  logic [ADDR-1:0]  rd_addr;
  logic [BUS_W-1:0] rd_w_data;
  logic [ADDR-1:0]  rs_addr;
  logic [ADDR-1:0]  rt_addr;
  logic [BUS_W-1:0] rs_data;
  logic [BUS_W-1:0] rt_data;

  int errors = 0;
  int checks = 0;

  register_file #(
    .ADDR  (ADDR),
    .BUS_W (BUS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r_write   (r_write),
    .rd_addr   (rd_addr),
    .rd_w_data (rd_w_data),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data)
  );

  initial clk = 1'b0;
  // Free-running 10ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BUS_W-1:0] obs,
                       input logic [BUS_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [ADDR-1:0] a, input logic [BUS_W-1:0] d);
    r_write   = 1'b1;
    rd_addr   = a;
    rd_w_data = d;
    tick();
    r_write   = 1'b0;
  endtask

  // Distinct per-address pattern touching every address bit in both halves of the word.
  function automatic logic [BUS_W-1:0] pattern(input int unsigned a);
    logic [BUS_W-1:0] p;
    p = {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    return p;
  endfunction

  initial begin
    rst       = 1'b1;
    r_write   = 1'b0;
    rd_addr   = '0;
    rd_w_data = '0;
    rs_addr   = '0;
    rt_addr   = '0;
    #1;

    // Reset held for two edges clears everything.
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      rs_addr = ADDR'(i);
      rt_addr = ADDR'(Depth - 1 - i);
      #1;
      check($sformatf("reset_rs[%0d]", i), rs_data, '0);
      check($sformatf("reset_rt[%0d]", Depth - 1 - i), rt_data, '0);
    end

    // Write reg1: old value before the edge, new value after (no bypass).
    r_write   = 1'b1;
    rd_addr   = 5'd1;
    rd_w_data = 32'd1;
    rs_addr   = 5'd1;
    rt_addr   = 5'd1;
    #1;
    check("pre_edge_rs1", rs_data, 32'd0);
    check("pre_edge_rt1", rt_data, 32'd0);
    tick();
    r_write = 1'b0;
    check("post_edge_rs1", rs_data, 32'd1);
    check("post_edge_rt1", rt_data, 32'd1);

    // Writes to register 0 are discarded.
    write_reg(5'd0, 32'hFFFF_FFFF);
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    #1;
    check("reg0_rs", rs_data, 32'd0);
    check("reg0_rt", rt_data, 32'd0);

    // r_write=0 leaves reg2 untouched.
    r_write   = 1'b0;
    rd_addr   = 5'd2;
    rd_w_data = 32'd2;
    tick();
    rs_addr = 5'd2;
    #1;
    check("no_write_reg2", rs_data, 32'd0);

    // Registers 3..9 hold their own address.
    for (int a = 3; a <= 9; a++) write_reg(ADDR'(a), BUS_W'(a));
    for (int a = 3; a <= 9; a++) begin
      rs_addr = ADDR'(a);
      rt_addr = ADDR'(a);
      #1;
      check($sformatf("own_addr_rs[%0d]", a), rs_data, BUS_W'(a));
      check($sformatf("own_addr_rt[%0d]", a), rt_data, BUS_W'(a));
    end
    rs_addr = 5'd1;
    #1;
    check("reg1_kept", rs_data, 32'd1);

    // Independent ports, combinational swap.
    write_reg(5'd5, 32'hA5A5_A5A5);
    rs_addr = 5'd5;
    rt_addr = 5'd3;
    #1;
    check("swap_a_rs", rs_data, 32'hA5A5_A5A5);
    check("swap_a_rt", rt_data, 32'd3);
    rs_addr = 5'd3;
    rt_addr = 5'd5;
    #1;
    check("swap_b_rs", rs_data, 32'd3);
    check("swap_b_rt", rt_data, 32'hA5A5_A5A5);

    // Fill every writable register with a unique pattern and read back on both ports.
    for (int a = 1; a < Depth; a++) write_reg(ADDR'(a), pattern(a));
    for (int a = 0; a < Depth; a++) begin
      rs_addr = ADDR'(a);
      rt_addr = ADDR'(Depth - 1 - a);
      #1;
      check($sformatf("fill_rs[%0d]", a), rs_data, (a == 0) ? '0 : pattern(a));
      check($sformatf("fill_rt[%0d]", Depth - 1 - a), rt_data,
            (a == Depth - 1) ? '0 : pattern(Depth - 1 - a));
    end

    // Reset wins over a simultaneous write and clears all earlier contents.
    rst       = 1'b1;
    r_write   = 1'b1;
    rd_addr   = 5'd7;
    rd_w_data = 32'd7;
    tick();
    rst     = 1'b0;
    r_write = 1'b0;
    for (int a = 0; a < Depth; a++) begin
      rs_addr = ADDR'(a);
      rt_addr = ADDR'(a);
      #1;
      check($sformatf("rst_prio_rs[%0d]", a), rs_data, '0);
      check($sformatf("rst_prio_rt[%0d]", a), rt_data, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
